// File: rtl/text_color_mapper_pipe_if.sv
// text_color_mapper_pipe_if
//   Bundles the pixel-path, palette-write, cursor and RGB output signals of
//   text_color_mapper_pipe. Clock and reset remain plain ports on the module.
//   master : pixel source / CPU side (drives coordinates, attributes, glyph,
//            palette writes, cursor; receives RGB)
//   slave  : the colour mapper itself
interface text_color_mapper_pipe_if #(
  parameter int COLOR_BITS = 4,
  parameter int PAL_DEPTH  = 16,
  parameter int FONT_W     = 8
);
  localparam int IDX_W = $clog2(PAL_DEPTH);

  logic [9:0]              DrawX;
  logic [9:0]              DrawY;
  logic                    pix_valid;
  logic                    frame_start;
  logic [FONT_W-1:0]       font_data;
  logic [IDX_W-1:0]        fg_idx;
  logic [IDX_W-1:0]        bg_idx;
  logic                    inverse;
  logic                    blink;
  logic                    pal_we;
  logic [IDX_W-1:0]        pal_waddr;
  logic [3*COLOR_BITS-1:0] pal_wdata;
  logic                    cursor_en;
  logic [6:0]              cursor_col;
  logic [4:0]              cursor_row;
  logic [COLOR_BITS-1:0]   Red;
  logic [COLOR_BITS-1:0]   Green;
  logic [COLOR_BITS-1:0]   Blue;
  logic                    rgb_valid;

  modport master (
    output DrawX, DrawY, pix_valid, frame_start, font_data, fg_idx, bg_idx,
           inverse, blink, pal_we, pal_waddr, pal_wdata, cursor_en,
           cursor_col, cursor_row,
    input  Red, Green, Blue, rgb_valid
  );

  modport slave (
    input  DrawX, DrawY, pix_valid, frame_start, font_data, fg_idx, bg_idx,
           inverse, blink, pal_we, pal_waddr, pal_wdata, cursor_en,
           cursor_col, cursor_row,
    output Red, Green, Blue, rgb_valid
  );
endinterface

// File: rtl/text_color_mapper_pipe.sv
// text_color_mapper_pipe
//   Text-mode pixel colour stage between the font ROM / char RAM fetch and the
//   video encoder. Attributes and coordinates are delayed FONT_LAT cycles to
//   line up with font_data, one glyph bit is picked, inverse / blink / cursor
//   are applied, and the resulting palette entry is registered onto RGB.
//   Latency DrawX -> RGB is FONT_LAT+1 cycles.
// Ports:
//   Clk, Reset  pixel clock, async active-high reset
//   bus (slave) DrawX/DrawY/pix_valid/attributes in, font_data in,
//               palette write port, cursor controls, Red/Green/Blue/rgb_valid out
// Build option:
//   CURSOR_BLINK_EN  when defined the cursor also blinks with blink_phase.
module text_color_mapper_pipe #(
  parameter int COLOR_BITS   = 4,
  parameter int PAL_DEPTH    = 16,
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int FONT_LAT     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input logic                     Clk,
  input logic                     Reset,
  text_color_mapper_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(PAL_DEPTH);
  localparam int XB    = $clog2(FONT_W);
  localparam int YB    = $clog2(FONT_H);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int RGB_W = 3*COLOR_BITS;

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [IDX_W-1:0] fg;
    logic [IDX_W-1:0] bg;
    logic             inv;
    logic             blk;
  } attr_t;

  // ---------------- Stage A: align attributes with font_data ----------------
  attr_t             attr_in;
  attr_t             attr_pipe [1:FONT_LAT];
  logic [FONT_LAT:1] vld_pipe;

  assign attr_in = '{x: bus.DrawX, y: bus.DrawY, fg: bus.fg_idx, bg: bus.bg_idx,
                     inv: bus.inverse, blk: bus.blink};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= FONT_LAT; i++) attr_pipe[i] <= '0;
    end else begin
      vld_pipe[1]  <= bus.pix_valid;
      attr_pipe[1] <= attr_in;
      for (int i = 2; i <= FONT_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        attr_pipe[i] <= attr_pipe[i-1];
      end
    end
  end

  // ---------------- Blink timebase ----------------
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES-1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // ---------------- Stage B: pixel select on aligned data ----------------
  attr_t            a;
  logic             vld_a;
  logic [XB-1:0]    bit_sel;
  logic             font_bit;
  logic             cursor_hit;
  logic             on;
  logic [IDX_W-1:0] sel;

  assign a       = attr_pipe[FONT_LAT];
  assign vld_a   = vld_pipe[FONT_LAT];
  // FONT_W is a power of two, so FONT_W-1-x equals the bitwise complement.
  assign bit_sel  = ~a.x[XB-1:0];
  assign font_bit = bus.font_data[bit_sel];

  // Underline cursor on the bottom two scanlines of the selected cell. Columns
  // and rows are compared zero-extended, so off-screen positions never match.
  always_comb begin
    cursor_hit = bus.cursor_en
              && (10'(a.x >> XB) == 10'(bus.cursor_col))
              && (10'(a.y >> YB) == 10'(bus.cursor_row))
              && (a.y[YB-1:0] >= YB'(FONT_H-2));
`ifdef CURSOR_BLINK_EN
    cursor_hit = cursor_hit && !blink_phase;
`endif
  end

  // Blink-off hides the glyph only; the cursor is XORed on afterwards.
  assign on  = ((a.blk && blink_phase) ? 1'b0 : (font_bit ^ a.inv)) ^ cursor_hit;
  assign sel = on ? a.fg : a.bg;

  // ---------------- Palette ----------------
  logic [RGB_W-1:0] pal [PAL_DEPTH];

  // Read in stage C samples pal before this edge's write lands, giving
  // old-data-on-collision behaviour without any bypass logic.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < PAL_DEPTH; i++)
        pal[i] <= (i == PAL_DEPTH-1) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
    end else if (bus.pal_we) begin
      pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  // ---------------- Stage C: registered RGB ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.rgb_valid                   <= 1'b0;
      {bus.Red, bus.Green, bus.Blue}  <= '0;
    end else begin
      bus.rgb_valid                   <= vld_a;
      {bus.Red, bus.Green, bus.Blue}  <= vld_a ? pal[sel] : {RGB_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_text_color_mapper_pipe.sv
// tb_text_color_mapper_pipe
//   Scoreboard bench for text_color_mapper_pipe: a driver issues one pixel per
//   cycle and pushes the expected {rgb_valid,R,G,B} from a behavioural model;
//   a monitor pops and compares one entry after every clock edge.
module tb_text_color_mapper_pipe;
  localparam int CB = 4, PD = 16, FW = 8, FH = 16, FL = 2, BF = 30;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  text_color_mapper_pipe_if #(.COLOR_BITS(CB), .PAL_DEPTH(PD), .FONT_W(FW)) bus ();

  text_color_mapper_pipe #(
    .COLOR_BITS(CB), .PAL_DEPTH(PD), .FONT_W(FW), .FONT_H(FH),
    .FONT_LAT(FL), .BLINK_FRAMES(BF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    bit          v;
    int          x, y, fg, bg;
    bit          inv, blk;
    logic [7:0]  glyph;
  } pix_t;

  // model state
  logic [11:0] m_pal [PD];
  int          m_cnt;
  bit          m_phase;
  bit          c_en;
  int          c_col, c_row;
  pix_t        hist [$];
  logic [12:0] exp_q [$];
  bit          mon_on = 0;
  int          checks = 0, errors = 0;

  task automatic check(string name, logic [12:0] got, logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got v=%0b rgb=%h required v=%0b rgb=%h",
               name, $time, got[12], got[11:0], exp[12], exp[11:0]);
    end
  endtask

  function automatic pix_t mk(bit v, int x, int y, int fg, int bg, bit inv, bit blk,
                              logic [7:0] g);
    pix_t p;
    p.v = v; p.x = x; p.y = y; p.fg = fg; p.bg = bg; p.inv = inv; p.blk = blk; p.glyph = g;
    return p;
  endfunction

  function automatic pix_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 8'h00);
  endfunction

  // Colour of a pixel from the textual rules: glyph bit, inverse, blink, cursor.
  function automatic logic [12:0] ref_px(pix_t q);
    bit b, hit, on;
    if (!q.v) return 13'h0;
    b   = q.glyph[FW-1 - (q.x % FW)];
    hit = c_en && (q.x / FW == c_col) && (q.y / FH == c_row) && (q.y % FH >= FH-2);
`ifdef CURSOR_BLINK_EN
    hit = hit && !m_phase;
`endif
    on  = ((q.blk && m_phase) ? 1'b0 : (b ^ q.inv)) ^ hit;
    return {1'b1, m_pal[on ? q.fg : q.bg]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < PD; i++) m_pal[i] = (i == PD-1) ? 12'hFFF : 12'h000;
    m_cnt = 0; m_phase = 0;
    hist.delete();
    for (int i = 0; i < FL; i++) hist.push_back(idle());
    exp_q.delete();
  endfunction

  // One pixel clock: drive pixel p; the glyph for the pixel issued FL cycles
  // ago goes out now and its colour is resolved against current model state.
  task automatic cyc(pix_t p, bit fs = 0, bit we = 0, int wa = 0, logic [11:0] wd = 12'h0);
    pix_t q;
    @(negedge Clk);
    bus.DrawX = 10'(p.x); bus.DrawY = 10'(p.y); bus.pix_valid = p.v;
    bus.fg_idx = 4'(p.fg); bus.bg_idx = 4'(p.bg);
    bus.inverse = p.inv; bus.blink = p.blk;
    bus.frame_start = fs; bus.pal_we = we; bus.pal_waddr = 4'(wa); bus.pal_wdata = wd;
    bus.cursor_en = c_en; bus.cursor_col = 7'(c_col); bus.cursor_row = 5'(c_row);
    hist.push_back(p);
    q = hist.pop_front();
    bus.font_data = q.glyph;
    exp_q.push_back(ref_px(q));
    if (we) m_pal[wa] = wd;
    if (fs) begin
      if (m_cnt == BF-1) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    mon_on = 0;
    bus.pix_valid = 0; bus.pal_we = 0; bus.frame_start = 0;
    #1 Reset = 1'b1;
    #1 check("async_reset_out", {bus.rgb_valid, bus.Red, bus.Green, bus.Blue}, 13'h0);
    // frame_start pulses while in reset must not advance the blink counter
    repeat (4) begin @(negedge Clk); bus.frame_start = ~bus.frame_start; end
    @(negedge Clk); bus.frame_start = 0;
    check("reset_hold_out", {bus.rgb_valid, bus.Red, bus.Green, bus.Blue}, 13'h0);
    model_reset();
    Reset = 1'b0;
    mon_on = 1;
  endtask

  // monitor
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge Clk); #1;
      if (mon_on && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel", {bus.rgb_valid, bus.Red, bus.Green, bus.Blue}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    pix_t p;
    int   x, y;
    bus.DrawX = 0; bus.DrawY = 0; bus.pix_valid = 0; bus.frame_start = 0;
    bus.font_data = 0; bus.fg_idx = 0; bus.bg_idx = 0; bus.inverse = 0; bus.blink = 0;
    bus.pal_we = 0; bus.pal_waddr = 0; bus.pal_wdata = 0;
    bus.cursor_en = 0; bus.cursor_col = 0; bus.cursor_row = 0;
    c_en = 0; c_col = 0; c_row = 0;
    do_reset();

    // default palette: entry 15 white, entry 1 black
    cyc(mk(1, 0, 0, 15, 1, 0, 0, 8'h80));
    cyc(mk(1, 1, 0, 15, 1, 0, 0, 8'h80));

    // palette setup, fg/bg select, inverse, blanking
    cyc(idle(), 0, 1, 1, 12'hF00);
    cyc(idle(), 0, 1, 2, 12'h00F);
    cyc(mk(1, 0, 0, 1, 2, 0, 0, 8'h80));
    cyc(mk(1, 1, 0, 1, 2, 0, 0, 8'h80));
    cyc(mk(1, 0, 0, 1, 2, 1, 0, 8'h80));
    cyc(idle());
    cyc(mk(1, 7, 3, 1, 2, 0, 0, 8'h01));

    // blink: 30 pulses hide the glyph, 30 more restore it
    for (int i = 0; i < BF; i++) cyc(mk(1, 0, 0, 1, 2, 0, 1, 8'h80), 1);
    repeat (4) cyc(mk(1, 0, 0, 1, 2, 0, 1, 8'h80));
    cyc(mk(1, 0, 0, 1, 2, 0, 0, 8'h80));
    for (int i = 0; i < BF; i++) cyc(mk(1, 0, 0, 1, 2, 0, 1, 8'h80), 1);
    repeat (4) cyc(mk(1, 0, 0, 1, 2, 0, 1, 8'h80));

    // cursor underline at cell (2,1): rows 30/31 hit, row 29 does not
    c_en = 1; c_col = 2; c_row = 1;
    for (int xx = 16; xx < 24; xx++) cyc(mk(1, xx, 30, 1, 2, 0, 0, 8'h00));
    for (int xx = 16; xx < 24; xx++) cyc(mk(1, xx, 29, 1, 2, 0, 0, 8'h00));
    cyc(mk(1, 15, 31, 1, 2, 0, 0, 8'h00));
    cyc(mk(1, 24, 31, 1, 2, 0, 0, 8'h00));
    c_col = 100;
    for (int xx = 16; xx < 24; xx++) cyc(mk(1, xx, 30, 1, 2, 0, 0, 8'h00));
    c_en = 0;

    // palette write colliding with the read of the same entry
    cyc(mk(1, 0, 0, 1, 2, 0, 0, 8'h80));
    cyc(mk(1, 0, 0, 1, 2, 0, 0, 8'h80));
    cyc(idle(), 0, 1, 1, 12'h0F0);
    cyc(idle());

    // mid-line reset, then defaults and first-valid latency
    cyc(mk(1, 3, 5, 1, 2, 0, 0, 8'hFF));
    cyc(mk(1, 4, 5, 1, 2, 0, 0, 8'hFF));
    do_reset();
    cyc(mk(1, 0, 0, 1, 2, 0, 0, 8'h80));
    cyc(mk(1, 0, 0, 15, 2, 0, 0, 8'h80));
    cyc(mk(1, 1, 0, 15, 1, 0, 0, 8'h80));
    cyc(idle());

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
      p = mk($urandom_range(0, 7) != 0, x, y, $urandom_range(0, PD-1), $urandom_range(0, PD-1),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      c_en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) != 0) begin
        // aim the cursor at the pixel being resolved this cycle
        c_col = (hist[0].x / FW) % 128;
        c_row = (hist[0].y / FH) % 32;
      end else begin
        c_col = $urandom_range(0, 127);
        c_row = $urandom_range(0, 31);
      end
      cyc(p, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, PD-1), 12'($urandom));
    end

    c_en = 0;
    repeat (FL + 2) cyc(idle());
    @(posedge Clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
